write_back_accumulator: RTL and testbench

Receiving end of the ALU write-back interface. Captures 64-word result blocks on each one-cycle accumulate strobe and sums them element-wise into an internal accumulator, for example to total partial dot products or convolutions over channels. On a flush command it drains the accumulator word by word to the DDR3 write port over a valid/ready handshake, then clears itself for the next accumulation run.

---
 rtl/write_back_accumulator.sv | 115 +++++++++++
 tb/tb_write_back_accumulator.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/write_back_accumulator.sv
// write_back_accumulator: sums 64-word ALU result blocks and drains the total to the DDR3 write port
// Optional build macro: SATURATE_ADD_EN selects signed saturating per-word adds instead of wrap-around.
module write_back_accumulator #(
    parameter int WORDS     = 64,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 27,
    parameter int ADDR_STEP = 4,
    parameter int CNT_W     = 8
) (
    input  logic                    iCLK,
    input  logic                    iRST_N,
    input  logic [WORDS*DATA_W-1:0] iBLOCK,
    input  logic                    iACCUMULATE,
    output logic                    oACC_READY,
    input  logic                    iFLUSH,
    input  logic [ADDR_W-1:0]       iBASE_ADDR,
    output logic                    oWR_VALID,
    input  logic                    iWR_READY,
    output logic [ADDR_W-1:0]       oWR_ADDR,
    output logic [DATA_W-1:0]       oWR_DATA,
    output logic                    oDONE,
    output logic [CNT_W-1:0]        oACC_COUNT,
    output logic                    oOVERRUN
);
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] acc [WORDS];
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  count;
    logic              done, overrun;
    logic              acc_en, flush_en, hs, last_hs;

    function automatic logic [DATA_W-1:0] add_word(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef SATURATE_ADD_EN
        logic [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        return (s[DATA_W] != s[DATA_W-1]) ? {s[DATA_W], {(DATA_W-1){~s[DATA_W]}}} : s[DATA_W-1:0];
`else
        return a + b;
`endif
    endfunction

    assign acc_en   = (state == IDLE) && iACCUMULATE;
    assign flush_en = (state == IDLE) && iFLUSH;
    assign hs       = (state == DRAIN) && iWR_READY;
    assign last_hs  = hs && (idx == IDX_W'(WORDS - 1));

    // state register
    always_ff @(posedge iCLK) begin
        state <= !iRST_N ? IDLE : state_nxt;
    end

    // next state: flush starts a drain, final handshake returns to idle
    always_comb begin
        state_nxt = flush_en ? DRAIN : last_hs ? IDLE : state;
    end

    // outputs decoded from state
    always_comb begin
        oWR_VALID  = (state == DRAIN);
        oACC_READY = (state == IDLE);
    end

    // element-wise accumulate; cleared once the last word has been written
    always_ff @(posedge iCLK) begin
        for (int k = 0; k < WORDS; k++) begin
            if (!iRST_N || last_hs)
                acc[k] <= '0;
            else if (acc_en)
                acc[k] <= add_word(acc[k], iBLOCK[k*DATA_W +: DATA_W]);
        end
    end

    // drain word index and latched base address
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            idx  <= '0;
            base <= '0;
        end else if (flush_en) begin
            idx  <= '0;
            base <= iBASE_ADDR;
        end else if (hs) begin
            idx  <= last_hs ? '0 : idx + 1'b1;
        end
    end

    // saturating strobe counter, cleared with the accumulator
    always_ff @(posedge iCLK) begin
        if (!iRST_N || last_hs)
            count <= '0;
        else if (acc_en && count != '1)
            count <= count + 1'b1;
    end

    // sticky overrun flag and one-cycle completion pulse
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            overrun <= 1'b0;
            done    <= 1'b0;
        end else begin
            overrun <= overrun | (iACCUMULATE && state != IDLE);
            done    <= last_hs;
        end
    end

    assign oWR_ADDR   = base + ADDR_W'(idx) * ADDR_W'(ADDR_STEP);
    assign oWR_DATA   = acc[idx];
    assign oDONE      = done;
    assign oACC_COUNT = count;
    assign oOVERRUN   = overrun;
endmodule

// File: tb/tb_write_back_accumulator.sv
// tb_write_back_accumulator: table vectors, directed corner cases and random runs against a behavioural model
module tb_write_back_accumulator;
    localparam int WORDS  = 64;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 27;
    localparam int CNT_W  = 8;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic                    iCLK = 1'b0;
    logic                    iRST_N = 1'b0;
    logic [WORDS*DATA_W-1:0] iBLOCK = '0;
    logic                    iACCUMULATE = 1'b0;
    logic                    oACC_READY;
    logic                    iFLUSH = 1'b0;
    logic [ADDR_W-1:0]       iBASE_ADDR = '0;
    logic                    oWR_VALID;
    logic                    iWR_READY = 1'b0;
    logic [ADDR_W-1:0]       oWR_ADDR;
    logic [DATA_W-1:0]       oWR_DATA;
    logic                    oDONE;
    logic [CNT_W-1:0]        oACC_COUNT;
    logic                    oOVERRUN;

    always #5 iCLK = ~iCLK;

    write_back_accumulator dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iBLOCK(iBLOCK), .iACCUMULATE(iACCUMULATE),
        .oACC_READY(oACC_READY), .iFLUSH(iFLUSH), .iBASE_ADDR(iBASE_ADDR),
        .oWR_VALID(oWR_VALID), .iWR_READY(iWR_READY), .oWR_ADDR(oWR_ADDR),
        .oWR_DATA(oWR_DATA), .oDONE(oDONE), .oACC_COUNT(oACC_COUNT), .oOVERRUN(oOVERRUN)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    int total = 0;
    int bad = 0;
    logic [DATA_W-1:0] m_acc [WORDS];
    logic [DATA_W-1:0] got [WORDS];
    int   m_cnt = 0;
    logic m_ovr = 1'b0;
    logic sat;
    vec_t vec [5];

    function automatic logic [31:0] madd(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'(signed'(a)) + longint'(signed'(b));
`ifdef SATURATE_ADD_EN
        if (s > MAXV) s = MAXV;
        if (s < MINV) s = MINV;
`endif
        return s[31:0];
    endfunction

    function automatic logic [WORDS*DATA_W-1:0] rand_blk();
        logic [WORDS*DATA_W-1:0] b;
        for (int k = 0; k < WORDS; k++) b[k*DATA_W +: DATA_W] = $urandom;
        return b;
    endfunction

    function automatic logic [WORDS*DATA_W-1:0] ramp_blk(input int mul, input int add);
        logic [WORDS*DATA_W-1:0] b;
        for (int k = 0; k < WORDS; k++) b[k*DATA_W +: DATA_W] = DATA_W'(k * mul + add);
        return b;
    endfunction

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", n, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < WORDS; k++) m_acc[k] = '0;
        m_cnt = 0;
    endtask

    task automatic accum(input logic [WORDS*DATA_W-1:0] b, input logic fl, input logic [ADDR_W-1:0] base);
        iBLOCK = b;
        iACCUMULATE = 1'b1;
        iFLUSH = fl;
        iBASE_ADDR = base;
        step();
        iACCUMULATE = 1'b0;
        iFLUSH = 1'b0;
        for (int k = 0; k < WORDS; k++) m_acc[k] = madd(m_acc[k], b[k*DATA_W +: DATA_W]);
        if (m_cnt < 255) m_cnt++;
        if (!fl) chk("acc_count", oACC_COUNT, m_cnt);
    endtask

    task automatic flush(input logic [ADDR_W-1:0] base);
        iFLUSH = 1'b1;
        iBASE_ADDR = base;
        step();
        iFLUSH = 1'b0;
        iBASE_ADDR = $urandom;
    endtask

    // mode 0: ready held high, 1: ready every other cycle, 2: random ready
    task automatic drain(input logic [ADDR_W-1:0] base, input int mode, input int strobe_at, input int abort_at);
        int idx = 0;
        int cyc = 0;
        logic [ADDR_W-1:0] ea;
        chk("drain_ready_low", oACC_READY, 0);
        while (idx < WORDS && cyc < 1000) begin
            ea = base + ADDR_W'(idx * 4);
            chk("wr_valid", oWR_VALID, 1);
            chk("wr_addr", oWR_ADDR, ea);
            chk("wr_data", oWR_DATA, m_acc[idx]);
            chk("done_early", oDONE, 0);
            if (idx == abort_at) begin
                iRST_N = 1'b0;
                iWR_READY = 1'b1;
                step();
                iRST_N = 1'b1;
                iWR_READY = 1'b0;
                chk("abort_valid", oWR_VALID, 0);
                chk("abort_ready", oACC_READY, 1);
                chk("abort_count", oACC_COUNT, 0);
                chk("abort_overrun", oOVERRUN, 0);
                model_clear();
                m_ovr = 1'b0;
                return;
            end
            iWR_READY = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 1) : 1'($urandom_range(0, 1));
            iACCUMULATE = (idx == strobe_at);
            if (iACCUMULATE) iBLOCK = rand_blk();
            if (iWR_READY) got[idx] = oWR_DATA;
            step();
            if (iACCUMULATE) m_ovr = 1'b1;
            iACCUMULATE = 1'b0;
            if (iWR_READY) idx++;
            cyc++;
        end
        iWR_READY = 1'b0;
        if (idx < WORDS) chk("drain_timeout", idx, WORDS);
        chk("done_pulse", oDONE, 1);
        chk("end_valid", oWR_VALID, 0);
        chk("end_ready", oACC_READY, 1);
        chk("end_count", oACC_COUNT, 0);
        chk("overrun", oOVERRUN, m_ovr);
        if (mode == 0) chk("latency", cyc, WORDS);
        model_clear();
        step();
        chk("done_one_cycle", oDONE, 0);
    endtask

    initial begin
`ifdef SATURATE_ADD_EN
        sat = 1'b1;
`else
        sat = 1'b0;
`endif
        vec[0] = '{32'h7FFFFFFF, 32'h7FFFFFFF, sat ? 32'h7FFFFFFF : 32'hFFFFFFFE};
        vec[1] = '{32'h80000000, 32'h80000000, sat ? 32'h80000000 : 32'h00000000};
        vec[2] = '{32'h00000005, 32'hFFFFFFFD, 32'h00000002};
        vec[3] = '{32'h80000001, 32'hFFFFFFFE, sat ? 32'h80000000 : 32'h7FFFFFFF};
        vec[4] = '{32'h7FFFFFF0, 32'h00000010, sat ? 32'h7FFFFFFF : 32'h80000000};
        model_clear();

        step();
        step();
        iRST_N = 1'b1;
        chk("rst_valid", oWR_VALID, 0);
        chk("rst_ready", oACC_READY, 1);
        chk("rst_done", oDONE, 0);
        chk("rst_count", oACC_COUNT, 0);
        chk("rst_overrun", oOVERRUN, 0);

        for (int i = 0; i < 3; i++) accum(ramp_blk(1, 1), 1'b0, '0);
        chk("count_before_flush", oACC_COUNT, 3);
        flush(27'h100);
        drain(27'h100, 0, -1, -1);
        chk("ramp_word0", got[0], 3);
        chk("ramp_word63", got[63], 192);

        accum(rand_blk(), 1'b0, '0);
        accum(rand_blk(), 1'b0, '0);
        flush(27'h2000);
        drain(27'h2000, 1, -1, -1);

        accum(ramp_blk(0, 5), 1'b1, 27'h400);
        drain(27'h400, 0, 10, -1);
        chk("same_cycle_word0", got[0], 5);
        chk("same_cycle_word63", got[63], 5);
        chk("overrun_sticky", oOVERRUN, 1);
        accum(ramp_blk(1, 1), 1'b0, '0);
        flush(27'h800);
        drain(27'h800, 2, -1, -1);
        chk("after_overrun_word7", got[7], 8);

        for (int i = 0; i < 5; i++) begin
            logic [WORDS*DATA_W-1:0] b;
            b = ramp_blk(3, 0);
            b[31:0] = vec[i].a;
            accum(b, 1'b0, '0);
            b[31:0] = vec[i].b;
            accum(b, 1'b0, '0);
            flush(27'h1000);
            drain(27'h1000, 0, -1, -1);
            chk("vec_word0", got[0], vec[i].exp);
        end

        accum(rand_blk(), 1'b0, '0);
        flush(27'h200);
        drain(27'h200, 0, -1, 20);
        flush(27'h3000);
        drain(27'h3000, 0, -1, -1);
        chk("post_abort_word0", got[0], 0);
        chk("post_abort_word20", got[20], 0);

        accum(rand_blk(), 1'b0, '0);
        flush(27'h7FFFFF0);
        drain(27'h7FFFFF0, 0, -1, -1);

        for (int i = 0; i < 260; i++) accum(rand_blk(), 1'b0, '0);
        chk("count_saturated", oACC_COUNT, 255);
        flush(27'h40);
        drain(27'h40, 2, -1, -1);

        for (int r = 0; r < 6; r++) begin
            logic [ADDR_W-1:0] base;
            int n;
            n = $urandom_range(0, 4);
            base = $urandom;
            for (int i = 0; i < n; i++) accum(rand_blk(), 1'b0, '0);
            flush(base);
            drain(base, $urandom_range(0, 2), (r == 3) ? 30 : -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
